sdu_uart_rx: RTL and testbench



---
 rtl/sdu_pkg.sv | 24 ++
 rtl/sdu_byte_fifo.sv | 69 ++++++
 rtl/sdu_uart_rx.sv | 136 +++++++++++++
 tb/tb_sdu_uart_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sdu_pkg.sv
// Shared constants and types for the serial debug unit UART.
// The transmitter imports the same baud default and divisor math.
package sdu_pkg;

  localparam int SDU_CLK_FREQ = 100_000_000;
  localparam int SDU_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  localparam int UART_DIV  = uart_div(SDU_CLK_FREQ, SDU_BAUD);
  localparam int UART_HALF = UART_DIV / 2;

endpackage

// File: rtl/sdu_byte_fifo.sv
// Small synchronous FIFO with a registered head entry and registered empty flag.
// A push into a full FIFO is dropped and flagged unless a pop frees the slot that cycle.
module sdu_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             full_c, pop_ok, push_ok;

  assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_c || pop_ok);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = din;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    empty_d = (wptr_d == rptr_d);
    // Reading the post-write image forwards a byte pushed into an empty FIFO.
    head_d = head_q;
    if (!empty_d) head_d = mem_d[rptr_d[AW-1:0]];
    ovf_d = push && !push_ok;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = head_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/sdu_uart_rx.sv
// UART 8N1 receive front end: synchronise, oversample, deframe LSB-first,
// and buffer bytes for the debug command parser.
module sdu_uart_rx
  import sdu_pkg::*;
#(
  parameter int CLK_FREQ   = SDU_CLK_FREQ,
  parameter int BAUD       = SDU_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DIV  = uart_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic            rx_meta_q, rx_s_q;
  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            frame_err_q, frame_err_d;
  logic            fifo_empty;

  // Synchroniser resets to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx_s = rx_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check mid start bit to reject glitches.
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held break reports once, then waits for the line to recover.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  sdu_byte_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push_q),
    .din     (shift_q),
    .pop     (dout_rdy),
    .dout    (dout),
    .empty   (fifo_empty),
    .overflow(overflow)
  );

  assign dout_vld  = !fifo_empty;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Directed bench for sdu_uart_rx with a byte scoreboard drained on the output handshake.
// Runs at a fast line rate (16 clocks per bit) to keep the cycle count small.
`timescale 1ns/1ps
module tb_sdu_uart_rx;

  localparam int      CLK_FREQ = 100_000_000;
  localparam int      BAUD     = 6_250_000;
  localparam int      DEPTH    = 4;
  localparam realtime BT       = 160.0;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       dout_rdy = 1'b0;
  logic [7:0] dout;
  logic       dout_vld, frame_err, overflow;

  int n_asrt = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q [$];

  sdu_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt++;
      if (overflow)  ov_cnt++;
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) chk("sb_unexpected_byte", 32'(dout), 32'hFFFF_FFFF);
        else                   chk("sb_byte", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tx_head(input logic [7:0] b, input realtime bt);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bt);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic stop_lvl, input realtime bt);
    tx_head(b, bt);
    rxd = stop_lvl;
    #(bt);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 dout_rdy = v;
  endtask

  initial begin
    int fe0, ov0;
    logic [7:0] b;
    realtime bts [3];
    bts[0] = BT;
    bts[1] = BT / 1.02;
    bts[2] = BT / 0.98;

    // Reset with idle line
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, latency around the stop-bit midpoint
    tx_head(8'h55, BT);
    rxd = 1'b1;
    #(BT / 2 - 20);
    chk("t1_vld_before_mid", 32'(dout_vld), 32'h0);
    #80;
    chk("t1_vld_after_mid", 32'(dout_vld), 32'h1);
    chk("t1_dout", 32'(dout), 32'h55);
    #(BT / 2 - 60);
    exp_q.push_back(8'h55);
    set_rdy(1'b1);
    repeat (4) @(negedge clk);
    chk("t1_vld_popped", 32'(dout_vld), 32'h0);
    chk("t1_drained", 32'(exp_q.size()), 32'h0);

    // Start-bit glitch
    fe0 = fe_cnt;
    @(negedge clk);
    rxd = 1'b0;
    #20;
    rxd = 1'b1;
    #120;
    chk("t2_no_vld", 32'(dout_vld), 32'h0);
    chk("t2_no_ferr", 32'(fe_cnt - fe0), 32'h0);

    // Framing error followed by a held break, then a clean byte
    tx_frame(8'hA3, 1'b0, BT);
    #(6 * BT);
    rxd = 1'b1;
    #(2 * BT);
    chk("t3_one_ferr", 32'(fe_cnt - fe0), 32'h1);
    chk("t3_no_push", 32'(dout_vld), 32'h0);
    exp_q.push_back(8'h3C);
    tx_frame(8'h3C, 1'b1, BT);
    #(2 * BT);
    chk("t3_drained", 32'(exp_q.size()), 32'h0);
    chk("t3_ferr_stable", 32'(fe_cnt - fe0), 32'h1);

    // Overflow: fifth byte into a full FIFO is dropped
    set_rdy(1'b0);
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) tx_frame(8'(i), 1'b1, BT);
    #(2 * BT);
    chk("t4_one_ovf", 32'(ov_cnt - ov0), 32'h1);
    chk("t4_vld", 32'(dout_vld), 32'h1);
    chk("t4_head", 32'(dout), 32'h01);
    set_rdy(1'b1);
    repeat (20) @(negedge clk);
    chk("t4_drained", 32'(exp_q.size()), 32'h0);
    chk("t4_empty", 32'(dout_vld), 32'h0);

    // Back-to-back streaming at nominal, +2% and -2% baud
    for (int p = 0; p < 3; p++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      for (int i = 0; i < 64; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        tx_frame(b, 1'b1, bts[p]);
      end
      #(2 * BT);
      chk($sformatf("t5_drained_p%0d", p), 32'(exp_q.size()), 32'h0);
      chk($sformatf("t5_no_ferr_p%0d", p), 32'(fe_cnt - fe0), 32'h0);
      chk($sformatf("t5_no_ovf_p%0d", p), 32'(ov_cnt - ov0), 32'h0);
    end

    // Reset in the middle of data bit 4, with a byte already buffered
    set_rdy(1'b0);
    tx_frame(8'h11, 1'b1, BT);
    #(2 * BT);
    chk("t6_pre_vld", 32'(dout_vld), 32'h1);
    chk("t6_pre_dout", 32'(dout), 32'h11);
    @(negedge clk);
    b = 8'hF0;
    rxd = 1'b0;
    #(BT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #(BT);
    end
    rxd = b[4];
    #(BT / 2);
    rstn = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(dout_vld), 32'h0);
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err), 32'h0);
    #19;
    rstn = 1'b1;
    for (int i = 5; i < 8; i++) begin
      #(BT / 2);
      rxd = b[i];
      #(BT / 2);
    end
    #(BT / 2 - 20);
    rxd = 1'b1;
    #(3 * BT);
    chk("t6_no_byte", 32'(dout_vld), 32'h0);
    set_rdy(1'b1);
    exp_q.push_back(8'h81);
    tx_frame(8'h81, 1'b1, BT);
    #(2 * BT);
    chk("t6_drained", 32'(exp_q.size()), 32'h0);
    chk("t6_final_empty", 32'(dout_vld), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
